// File: rtl/pipelined_datapath.sv
// Two-stage (EX -> WB) register-file/ALU/data-memory datapath with WB-to-EX forwarding
// and registered branch flags; one micro-op per cycle, never stalls.
module pipelined_datapath #(
    parameter int WIDTH     = 16,
    parameter int REG_COUNT = 8,
    parameter int MEM_DEPTH = 32,
    localparam int RA = $clog2(REG_COUNT),
    localparam int MA = $clog2(MEM_DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             op_valid,
    input  logic             rf_write,
    input  logic [RA-1:0]    rs_addr,
    input  logic [RA-1:0]    rt_addr,
    input  logic [RA-1:0]    rd_addr,
    input  logic [WIDTH-1:0] imm_data,
    input  logic             imm_sel,
    input  logic [3:0]       alu_sel,
    input  logic             mem_write,
    input  logic             mem_sel,
    output logic             zero_flag,
    output logic             pos_flag,
    output logic             flag_valid,
    output logic [WIDTH-1:0] last_reg_data
);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOT  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_PASS = 4'd8
    } alu_op_e;

    logic [WIDTH-1:0] r_rf [REG_COUNT];
    logic [WIDTH-1:0] r_mem [MEM_DEPTH];

    logic             r_wb_valid;
    logic             r_wb_rf_write;
    logic [RA-1:0]    r_wb_rd;
    logic             r_wb_mem_sel;
    logic [WIDTH-1:0] r_wb_alu;
    logic [WIDTH-1:0] r_mem_rdata;
    logic             r_zero_flag;
    logic             r_pos_flag;
    logic             r_flag_valid;

    logic [WIDTH-1:0] w_wb_result;
    logic             w_wb_writes;
    logic [WIDTH-1:0] w_rs_val;
    logic [WIDTH-1:0] w_rt_val;
    logic [WIDTH-1:0] w_in1;
    logic [WIDTH-1:0] w_alu_out;
    logic [MA-1:0]    w_mem_addr;

    // Load data is already registered, so the WB result is final and can be forwarded as-is.
    assign w_wb_result = r_wb_mem_sel ? r_mem_rdata : r_wb_alu;
    assign w_wb_writes = r_wb_valid && r_wb_rf_write;

    assign w_rs_val   = (w_wb_writes && r_wb_rd == rs_addr) ? w_wb_result : r_rf[rs_addr];
    assign w_rt_val   = (w_wb_writes && r_wb_rd == rt_addr) ? w_wb_result : r_rf[rt_addr];
    assign w_in1      = imm_sel ? imm_data : w_rt_val;
    assign w_mem_addr = w_alu_out[MA-1:0];

    always_comb begin
        // NOTE: default first so every path assigns w_alu_out and no latch is inferred.
        w_alu_out = '0;
        case (alu_sel)
            ALU_ADD:  w_alu_out = w_rs_val + w_in1;
            ALU_SUB:  w_alu_out = w_rs_val - w_in1;
            ALU_AND:  w_alu_out = w_rs_val & w_in1;
            ALU_OR:   w_alu_out = w_rs_val | w_in1;
            ALU_XOR:  w_alu_out = w_rs_val ^ w_in1;
            ALU_NOT:  w_alu_out = ~w_rs_val;
            ALU_SLL:  w_alu_out = w_rs_val << w_in1[3:0];
            ALU_SRL:  w_alu_out = w_rs_val >> w_in1[3:0];
            ALU_PASS: w_alu_out = w_in1;
            default:  w_alu_out = '0;
        endcase
    end

    // NOTE: data memory has no reset so it maps onto plain RAM; contents survive a reset.
    always_ff @(posedge clock) begin
        if (!reset && op_valid && mem_write) begin
            r_mem[w_mem_addr] <= w_rs_val;
        end
        r_mem_rdata <= r_mem[w_mem_addr];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: non-blocking throughout, so WB reads the old pipeline state at this edge.
            r_wb_valid    <= 1'b0;
            r_wb_rf_write <= 1'b0;
            r_wb_rd       <= '0;
            r_wb_mem_sel  <= 1'b0;
            r_wb_alu      <= '0;
            r_zero_flag   <= 1'b0;
            r_pos_flag    <= 1'b0;
            r_flag_valid  <= 1'b0;
            for (int i = 0; i < REG_COUNT; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            r_wb_valid    <= op_valid;
            r_wb_rf_write <= rf_write;
            r_wb_rd       <= rd_addr;
            r_wb_mem_sel  <= mem_sel;
            r_wb_alu      <= w_alu_out;
            if (w_wb_writes) begin
                r_rf[r_wb_rd] <= w_wb_result;
            end
            r_flag_valid <= r_wb_valid;
            if (r_wb_valid) begin
                r_zero_flag <= (w_wb_result == '0);
                r_pos_flag  <= ~w_wb_result[WIDTH-1];
            end
        end
    end

    assign zero_flag     = r_zero_flag;
    assign pos_flag      = r_pos_flag;
    assign flag_valid    = r_flag_valid;
    assign last_reg_data = r_rf[REG_COUNT-1];

endmodule
